// File: rtl/dilithium_byte_packer.sv
`default_nettype none
// ============================================================================
// Module  : dilithium_byte_packer
// Brief   : Packs a little-endian byte stream into W-bit words (W = 32 or 64)
//           for the Dilithium core input. A short final word is zero-padded.
//           Optional word counter port: define DILITHIUM_PACKER_COUNT_EN.
// Revision: 1.0
// ============================================================================
module dilithium_byte_packer #(
    parameter int W = 64
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [7:0]   in_data,
    input  logic         in_last,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data,
    output logic         out_last
`ifdef DILITHIUM_PACKER_COUNT_EN
    ,
    output logic [15:0]  word_count
`endif
);

    localparam int NB = W / 8;
    localparam int IW = $clog2(NB);
    localparam logic [IW-1:0] LAST_IDX = IW'(NB - 1);

    typedef enum logic [0:0] {
        FILL  = 1'b0,
        FLUSH = 1'b1
    } state_t;

    state_t         state_q;
    logic [W-1:0]   acc_q;
    logic [W-1:0]   acc_d;
    logic [IW-1:0]  idx_q;
    logic           acc_last_q;
    logic [W-1:0]   out_data_q;
    logic           out_valid_q;
    logic           out_last_q;

    logic           w_out_free;
    logic           w_accept;
    logic           w_complete;

    assign w_out_free = !out_valid_q || out_ready;
    // A held word only blocks the byte that would complete the next one.
    assign in_ready   = (state_q == FILL) && (w_out_free || (idx_q != LAST_IDX));
    assign w_accept   = in_valid && in_ready;
    assign w_complete = (idx_q == LAST_IDX) || in_last;

    always_comb begin
        acc_d = acc_q;
        for (int k = 0; k < NB; k++) begin
            if (idx_q == IW'(k)) begin
                acc_d[8*k +: 8] = in_data;
            end
        end
    end

`ifdef DILITHIUM_PACKER_COUNT_EN
    logic [15:0] word_count_q;
    assign word_count = word_count_q;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= FILL;
            acc_q       <= '0;
            idx_q       <= '0;
            acc_last_q  <= 1'b0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
`ifdef DILITHIUM_PACKER_COUNT_EN
            word_count_q <= '0;
`endif
        end else begin
            // Consume drops valid unless a load below overrides it.
            if (out_valid_q && out_ready) begin
                out_valid_q <= 1'b0;
            end
`ifdef DILITHIUM_PACKER_COUNT_EN
            if (out_valid_q && out_ready) begin
                word_count_q <= word_count_q + 16'd1;
            end
`endif
            case (state_q)
                FILL: begin
                    if (w_accept) begin
                        if (w_complete && w_out_free) begin
                            out_data_q  <= acc_d;
                            out_last_q  <= in_last;
                            out_valid_q <= 1'b1;
                            acc_q       <= '0;
                            idx_q       <= '0;
                            acc_last_q  <= 1'b0;
                        end else if (w_complete) begin
                            acc_q      <= acc_d;
                            acc_last_q <= 1'b1;
                            state_q    <= FLUSH;
                        end else begin
                            acc_q <= acc_d;
                            idx_q <= idx_q + IW'(1);
                        end
                    end
                end
                FLUSH: begin
                    if (w_out_free) begin
                        out_data_q  <= acc_q;
                        out_last_q  <= acc_last_q;
                        out_valid_q <= 1'b1;
                        acc_q       <= '0;
                        idx_q       <= '0;
                        acc_last_q  <= 1'b0;
                        state_q     <= FILL;
                    end
                end
                default: begin
                    state_q <= FILL;
                end
            endcase
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_last  = out_last_q;

endmodule
`default_nettype wire

// File: tb/tb_dilithium_byte_packer.sv
`default_nettype none
// ============================================================================
// Module  : tb_dilithium_byte_packer
// Brief   : Directed and random stimulus for dilithium_byte_packer, checked
//           against a word-queue model. DILITHIUM_PACKER_COUNT_EN adds counter.
// Revision: 1.0
// ============================================================================
module tb_dilithium_byte_packer;

    localparam int W  = 64;
    localparam int NB = W / 8;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         in_valid = 1'b0;
    logic [7:0]   in_data = 8'h00;
    logic         in_last = 1'b0;
    logic         out_ready = 1'b0;
    logic         in_ready;
    logic         out_valid;
    logic [W-1:0] out_data;
    logic         out_last;
`ifdef DILITHIUM_PACKER_COUNT_EN
    logic [15:0]  word_count;
`endif

    int checks = 0;
    int errors = 0;

    dilithium_byte_packer #(.W(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_last  (out_last)
`ifdef DILITHIUM_PACKER_COUNT_EN
        ,
        .word_count(word_count)
`endif
    );

    always #5 clk = ~clk;

    // Model: completed words waiting to leave (head = output register,
    // a second entry = word parked for flush) plus the bytes of the open word.
    logic [W-1:0] eq_data[$];
    logic         eq_last[$];
    logic [7:0]   pb[$];
    logic [15:0]  mcount = 16'd0;
    logic [W-1:0] mword;
    bit           m_acc;
    bit           m_cons;

    function automatic logic exp_ready();
        if (eq_data.size() >= 2) return 1'b0;
        return (eq_data.size() == 0) || out_ready || (pb.size() < NB - 1);
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    always @(posedge clk) begin
        if (!rst) begin
            eq_data.delete();
            eq_last.delete();
            pb.delete();
            mcount = 16'd0;
        end else begin
            m_acc  = in_valid && exp_ready();
            m_cons = (eq_data.size() > 0) && out_ready;
            if (m_cons) begin
                void'(eq_data.pop_front());
                void'(eq_last.pop_front());
                mcount = mcount + 16'd1;
            end
            if (m_acc) begin
                pb.push_back(in_data);
                if (in_last || pb.size() == NB) begin
                    mword = '0;
                    foreach (pb[i]) mword[8*i +: 8] = pb[i];
                    eq_data.push_back(mword);
                    eq_last.push_back(in_last);
                    pb.delete();
                end
            end
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            chk("rst_out_valid", 64'(out_valid), 64'd0);
            chk("rst_out_data",  64'(out_data),  64'd0);
            chk("rst_out_last",  64'(out_last),  64'd0);
            chk("rst_in_ready",  64'(in_ready),  64'd1);
`ifdef DILITHIUM_PACKER_COUNT_EN
            chk("rst_word_count", 64'(word_count), 64'd0);
`endif
        end else begin
            chk("in_ready",  64'(in_ready),  64'(exp_ready()));
            chk("out_valid", 64'(out_valid), 64'(eq_data.size() > 0));
            if (eq_data.size() > 0) begin
                chk("out_data", 64'(out_data), 64'(eq_data[0]));
                chk("out_last", 64'(out_last), 64'(eq_last[0]));
            end
`ifdef DILITHIUM_PACKER_COUNT_EN
            chk("word_count", 64'(word_count), 64'(mcount));
`endif
        end
    end

    // Returns #1 after the edge on which the byte was accepted.
    task automatic send_byte(input logic [7:0] d, input logic l);
        int n;
        n = 0;
        in_valid = 1'b1;
        in_data  = d;
        in_last  = l;
        @(negedge clk);
        while (!in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: byte %h never accepted", d);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;

        // Full word, back-to-back
        out_ready = 1'b1;
        for (int i = 1; i <= 8; i++) send_byte(8'(i), i == 8);
        chk("full_data",  64'(out_data),  64'h0807060504030201);
        chk("full_last",  64'(out_last),  64'd1);
        chk("full_valid", 64'(out_valid), 64'd1);
        tick();
        chk("full_valid_drop", 64'(out_valid), 64'd0);

        // Padded final word
        send_byte(8'hAA, 1'b0);
        send_byte(8'hBB, 1'b0);
        send_byte(8'hCC, 1'b1);
        chk("pad_data", 64'(out_data), 64'h0000000000CCBBAA);
        chk("pad_last", 64'(out_last), 64'd1);
        tick();

        // Backpressure
        out_ready = 1'b0;
        for (int i = 0; i < 15; i++) send_byte(8'(i), 1'b0);
        in_valid = 1'b1;
        in_data  = 8'h0F;
        in_last  = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("bp_stall", 64'(in_ready), 64'd0);
        end
        tick();
        chk("bp_word0", 64'(out_data), 64'h0706050403020100);
        out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        in_last  = 1'b0;
        chk("bp_word1", 64'(out_data), 64'h0F0E0D0C0B0A0908);
        chk("bp_last1", 64'(out_last), 64'd1);
        tick();

        // Flush path
        out_ready = 1'b0;
        for (int i = 0; i < 8; i++) send_byte(8'(8'h31 + i), 1'b0);
        send_byte(8'h11, 1'b0);
        send_byte(8'h22, 1'b1);
        @(negedge clk);
        chk("flush_ready_low", 64'(in_ready), 64'd0);
        repeat (2) tick();
        chk("flush_held", 64'(out_data), 64'h3837363534333231);
        out_ready = 1'b1;
        tick();
        chk("flush_data",  64'(out_data), 64'h0000000000002211);
        chk("flush_last",  64'(out_last), 64'd1);
        chk("flush_ready", 64'(in_ready), 64'd1);
        tick();
        chk("flush_drained", 64'(out_valid), 64'd0);

        // Reset mid-message
        for (int i = 0; i < 5; i++) send_byte(8'(8'h50 + i), 1'b0);
        rst = 1'b0;
        repeat (2) tick();
        rst = 1'b1;
        for (int i = 1; i <= 8; i++) send_byte(8'(i), i == 8);
        chk("rstmid_data", 64'(out_data), 64'h0807060504030201);
        tick();

        // Random traffic
        for (int c = 0; c < 4000; c++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            in_data   = 8'($urandom);
            in_last   = ($urandom_range(0, 7) == 0);
            out_ready = ((c / 64) % 3 == 2) ? 1'b0 : ($urandom_range(0, 2) != 0);
            tick();
        end
        in_valid  = 1'b0;
        in_last   = 1'b0;
        out_ready = 1'b1;
        repeat (4) tick();

`ifdef DILITHIUM_PACKER_COUNT_EN
        rst = 1'b0;
        repeat (2) tick();
        rst = 1'b1;
        for (int i = 0; i < 3; i++) send_byte(8'(i), 1'b1);
        repeat (2) tick();
        chk("count_three", 64'(word_count), 64'd3);
        in_valid = 1'b1;
        in_last  = 1'b1;
        for (int i = 3; i < 65536; i++) begin
            in_data = 8'(i);
            tick();
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        repeat (2) tick();
        chk("count_wrap", 64'(word_count), 64'd0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
